// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU: opcode encodings, FSM state type
// and flag bit positions within the {N,Z,C,V} flags vector.
package alu_seq_pkg;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_SKZ = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_LDA = 4'h5;
    localparam logic [3:0] OP_STO = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_SUB = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_SRA = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the issue side, the ALU and the
// write-back consumer. The ALU uses the slave view; the driver uses master.
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic [3:0]       flags;
    logic             a_is_zero;
    logic             op_err;

    modport master (
        output in_valid, opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, alu_out, flags, a_is_zero, op_err
    );

    modport slave (
        input  in_valid, opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, alu_out, flags, a_is_zero, op_err
    );
endinterface

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath: legacy ops, SUB, OR and flag generation.
// Shift opcodes reaching this block are the amount-0 case (pass A, C=0);
// opcode D and E/F are illegal here (pass A with op_err).
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flg,
    output logic             err
);
    logic [WIDTH:0] add_x;
    logic [WIDTH:0] sub_x;
    logic           c_bit;
    logic           v_bit;

    // Result, carry/overflow and N/Z selection for the single-cycle ops
    always_comb begin
        add_x = {1'b0, a} + {1'b0, b};
        sub_x = {1'b0, a} - {1'b0, b};
        res   = a;
        c_bit = 1'b0;
        v_bit = 1'b0;
        err   = 1'b0;
        case (opcode)
            OP_HLT, OP_SKZ, OP_STO, OP_JMP: res = a;
            OP_ADD: begin
                res   = add_x[WIDTH-1:0];
                c_bit = add_x[WIDTH];
                v_bit = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_XOR: res = a ^ b;
            OP_LDA: res = b;
            OP_SUB: begin
                res   = sub_x[WIDTH-1:0];
                c_bit = sub_x[WIDTH];
                v_bit = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR: res = a | b;
            OP_SHL, OP_SHR, OP_SRA: res = a;
            default: begin
                res = a;
                err = 1'b1;
            end
        endcase
        flg        = '0;
        flg[FLG_N] = res[WIDTH-1];
        flg[FLG_Z] = (res == '0);
        flg[FLG_C] = c_bit;
        flg[FLG_V] = v_bit;
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: IDLE/EXEC/DONE sequencer, bit-serial shifter
// and (with ALU_MUL_EN defined) a shift-add multiplier for opcode D.
// Without ALU_MUL_EN opcode D is an illegal, single-cycle op.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = SHW + 1;

    state_t           state, state_n;
    logic             in_ready_c;
    logic             accept;
    logic             start_exec;
    logic [SHW-1:0]   amt;

    logic [3:0]       opc_q;
    logic [WIDTH-1:0] work_q;
    logic [CW-1:0]    cnt_q;
    logic             az_q;

    logic [WIDTH-1:0] alu_out_q;
    logic [3:0]       flags_q;
    logic             a_is_zero_q;
    logic             op_err_q;

    logic [WIDTH-1:0] comb_res;
    logic [3:0]       comb_flg;
    logic             comb_err;

    logic [WIDTH-1:0] shift_n;
    logic             shift_c;
    logic [WIDTH-1:0] exec_res;
    logic             exec_c;
    logic             exec_v;
    logic [3:0]       exec_flg;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     psum;
`endif

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .opcode (bus.opcode),
        .a      (bus.in_a),
        .b      (bus.in_b),
        .res    (comb_res),
        .flg    (comb_flg),
        .err    (comb_err)
    );

    assign amt = bus.in_b[SHW-1:0];

    // Decide whether an accepted op needs the multi-cycle EXEC phase
    always_comb begin
        start_exec = is_shift(bus.opcode) && (amt != '0);
`ifdef ALU_MUL_EN
        if (bus.opcode == OP_MUL) start_exec = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n    = state;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: in_ready_c = 1'b1;
            EXEC: if (cnt_q == CW'(1)) state_n = DONE;
            DONE: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (in_ready_c && bus.in_valid) begin
            accept  = 1'b1;
            state_n = start_exec ? EXEC : DONE;
        end
    end

    // One EXEC step: shifter next value, and the shift-add product step
    always_comb begin
        shift_n = work_q;
        shift_c = 1'b0;
        case (opc_q)
            OP_SHL: begin
                shift_n = {work_q[WIDTH-2:0], 1'b0};
                shift_c = work_q[WIDTH-1];
            end
            OP_SHR: begin
                shift_n = {1'b0, work_q[WIDTH-1:1]};
                shift_c = work_q[0];
            end
            OP_SRA: begin
                shift_n = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                shift_c = work_q[0];
            end
            default: ;
        endcase
        exec_res = shift_n;
        exec_c   = shift_c;
        exec_v   = 1'b0;
`ifdef ALU_MUL_EN
        psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_n = {psum, prod_q[WIDTH-1:1]};
        if (opc_q == OP_MUL) begin
            exec_res = prod_n[WIDTH-1:0];
            exec_c   = |prod_n[2*WIDTH-1:WIDTH];
            exec_v   = exec_c;
        end
`endif
        exec_flg        = '0;
        exec_flg[FLG_N] = exec_res[WIDTH-1];
        exec_flg[FLG_Z] = (exec_res == '0);
        exec_flg[FLG_C] = exec_c;
        exec_flg[FLG_V] = exec_v;
    end

    // Operand capture, EXEC sequencing and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q       <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            az_q        <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
            a_is_zero_q <= 1'b0;
            op_err_q    <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q      <= '0;
            mcand_q     <= '0;
`endif
        end else if (accept) begin
            opc_q  <= bus.opcode;
            work_q <= bus.in_a;
            az_q   <= (bus.in_a == '0);
            cnt_q  <= CW'(amt);
`ifdef ALU_MUL_EN
            prod_q  <= {{WIDTH{1'b0}}, bus.in_b};
            mcand_q <= bus.in_a;
            if (bus.opcode == OP_MUL) cnt_q <= CW'(WIDTH);
`endif
            if (!start_exec) begin
                alu_out_q   <= comb_res;
                flags_q     <= comb_flg;
                op_err_q    <= comb_err;
                a_is_zero_q <= (bus.in_a == '0);
            end
        end else if (state == EXEC) begin
            cnt_q  <= cnt_q - CW'(1);
            work_q <= shift_n;
`ifdef ALU_MUL_EN
            prod_q <= prod_n;
`endif
            if (cnt_q == CW'(1)) begin
                alu_out_q   <= exec_res;
                flags_q     <= exec_flg;
                op_err_q    <= 1'b0;
                a_is_zero_q <= az_q;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == DONE);
    assign bus.alu_out   = alu_out_q;
    assign bus.flags     = flags_q;
    assign bus.a_is_zero = a_is_zero_q;
    assign bus.op_err    = op_err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, back-to-back and random
// ops checked against an arithmetic reference model, back-pressure and
// mid-operation reset. Honours ALU_MUL_EN the same way the design does.
module tb_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic from the opcode rules
    function automatic void model(input int unsigned op, input int unsigned a, input int unsigned b,
                                  output int unsigned res, output logic [3:0] fl,
                                  output logic err, output int unsigned lat);
        int unsigned m = 1 << W;
        int unsigned k = b % W;
        int sa = (a >= m / 2) ? int'(a) - int'(m) : int'(a);
        int sb = (b >= m / 2) ? int'(b) - int'(m) : int'(b);
        int s;
        int unsigned full;
        logic c = 1'b0;
        logic v = 1'b0;
        err = 1'b0;
        lat = 1;
        res = a;
        case (op)
            2: begin
                full = a + b; res = full % m; c = (full >= m);
                s = sa + sb; v = (s > int'(m / 2) - 1) || (s < -int'(m / 2));
            end
            3: res = a & b;
            4: res = a ^ b;
            5: res = b;
            8: begin
                res = (a + m - b) % m; c = (a < b);
                s = sa - sb; v = (s > int'(m / 2) - 1) || (s < -int'(m / 2));
            end
            9: res = a | b;
            10: if (k != 0) begin
                res = (a << k) % m; c = ((a >> (W - k)) & 1) != 0; lat = 1 + k;
            end
            11: if (k != 0) begin
                res = a >> k; c = ((a >> (k - 1)) & 1) != 0; lat = 1 + k;
            end
            12: if (k != 0) begin
                s = sa >>> k; res = int'(s) & (m - 1);
                c = ((a >> (k - 1)) & 1) != 0; lat = 1 + k;
            end
`ifdef ALU_MUL_EN
            13: begin
                full = a * b; res = full % m; c = (full / m) != 0; v = c; lat = W + 1;
            end
`else
            13: err = 1'b1;
`endif
            14, 15: err = 1'b1;
            default: res = a;
        endcase
        fl = {res >= m / 2, res == 0, c, v};
    endfunction

    task automatic check_result(input string tag, input int unsigned op, input int unsigned a,
                                input int unsigned b);
        int unsigned er, elat;
        logic [3:0] ef;
        logic ee;
        model(op, a, b, er, ef, ee, elat);
        check({tag, "_out_valid"}, bus.out_valid, 1);
        check({tag, "_alu_out"}, bus.alu_out, er);
        check({tag, "_flags"}, bus.flags, ef);
        check({tag, "_op_err"}, bus.op_err, ee);
        check({tag, "_a_is_zero"}, bus.a_is_zero, a == 0);
    endtask

    // Issue one op from idle with out_ready high, wait for and check the result
    task automatic run_op(input string tag, input int unsigned op, input int unsigned a,
                          input int unsigned b);
        int unsigned er, elat, lat;
        logic [3:0] ef;
        logic ee;
        model(op, a, b, er, ef, ee, elat);
        @(negedge clk);
        bus.opcode = 4'(op); bus.in_a = W'(a); bus.in_b = W'(b);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        check({tag, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            check({tag, "_busy_in_ready"}, bus.in_ready, 0);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, elat);
        check_result(tag, op, a, b);
    endtask

    initial begin
        int unsigned pop, pa, pb, op, a, b;
        int unsigned singles[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 14, 15};

        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.opcode = '0; bus.in_a = '0; bus.in_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_alu_out", bus.alu_out, 0);
        check("rst_flags", bus.flags, 0);
        check("rst_a_is_zero", bus.a_is_zero, 0);
        check("rst_op_err", bus.op_err, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Directed cases
        run_op("add_ovf", 2, 8'h7F, 8'h01);
        @(negedge clk);
        check("add_ovf_one_cycle", bus.out_valid, 0);
        run_op("sub_borrow", 8, 8'h00, 8'h01);
        run_op("illegal_e", 14, 8'h5A, 8'h33);
        run_op("illegal_f", 15, 8'h00, 8'h01);
        run_op("shl3", 10, 8'h81, 8'h03);
        run_op("shr0", 11, 8'hC3, 8'h08);
        run_op("sra7", 12, 8'h80, 8'h07);
        run_op("mul", 13, 8'h10, 8'h20);
        run_op("mul_max", 13, 8'hFF, 8'hFF);

        // Back-to-back single-cycle ops with out_ready held high
        pop = 0; pa = 0; pb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) check_result("b2b", pop, pa, pb);
            op = singles[$urandom_range(0, 11)];
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            bus.opcode = 4'(op); bus.in_a = W'(a); bus.in_b = W'(b);
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            check("b2b_in_ready", bus.in_ready, 1);
            pop = op; pa = a; pb = b;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_result("b2b_last", pop, pa, pb);

        // Random ops over the whole opcode space
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 15);
            a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            run_op("rand", op, a, b);
        end

        // Back-pressure: result held while out_ready is low
        @(negedge clk);
        bus.opcode = 4'h2; bus.in_a = 8'h03; bus.in_b = 8'h04;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.opcode = 4'h4; bus.in_a = 8'h5A; bus.in_b = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_alu_out", bus.alu_out, 8'h07);
            check("bp_in_ready", bus.in_ready, 0);
            bus.in_valid = (i == 2);
        end
        bus.out_ready = 1'b1;
        bus.opcode = 4'h4; bus.in_a = 8'hF0; bus.in_b = 8'h0F;
        bus.in_valid = 1'b1;
        #1;
        check("bp_release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_result("bp_xor", 4, 8'hF0, 8'h0F);

        // Reset in the middle of a multi-cycle op
        @(negedge clk);
`ifdef ALU_MUL_EN
        bus.opcode = 4'hD; bus.in_a = 8'h37; bus.in_b = 8'h29;
`else
        bus.opcode = 4'hA; bus.in_a = 8'h37; bus.in_b = 8'h07;
`endif
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_alu_out", bus.alu_out, 0);
        check("mid_rst_flags", bus.flags, 0);
        check("mid_rst_op_err", bus.op_err, 0);
        check("mid_rst_a_is_zero", bus.a_is_zero, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", bus.out_valid, 0);
        end
        run_op("post_rst_add", 2, 8'hFF, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked, multi-cycle successor to the VeriRISC combinational ALU. Keeps the legacy 3-bit opcode behaviour under opcode[3]=0 and adds SUB, OR, shifts and an optional shift-add multiplier. Also adds N/Z/C/V flags and valid/ready flow control on both sides. Sits between the instruction decoder/operand registers and the accumulator write-back of the next-generation core.

## Interface
- WIDTH, 8, operand/result width (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount field width taken from in_b[SHW-1:0]
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- opcode  in  4  operation select
- in_a  in  WIDTH  operand A (accumulator)
- in_b  in  WIDTH  operand B (memory data / shift amount)
- out_valid  out  1  result held on outputs
- out_ready  in  1  consumer takes result
- alu_out  out  WIDTH  registered result
- flags  out  4  {N,Z,C,V} of the result
- a_is_zero  out  1  captured in_a == 0 (for SKZ)
- op_err  out  1  result came from an illegal/disabled opcode

## Operation
- Opcodes: 0,1,6,7 pass A; 2 ADD; 3 AND; 4 XOR; 5 pass B; 8 SUB (A−B); 9 OR; A SHL; B SHR logical; C SRA; D MUL; E,F illegal.
- Illegal opcodes produce pass A with op_err=1. All other opcodes produce op_err=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE: on in_valid&&in_ready, capture opcode/in_a/in_b.
  - Single-cycle ops, and shifts with amount 0, go to DONE.
  - Shifts with amount>0 go to EXEC with counter=amount. MUL goes to EXEC with counter=WIDTH.
- EXEC: shifts move one bit per cycle and decrement the counter. MUL does one shift-add step per cycle into a 2·WIDTH product register. Go to DONE when counter reaches 1 on the final step.
- DONE: out_valid=1, and outputs are held stable until out_ready.
  - On out_ready with a new in_valid: accept it in the same cycle, with the same routing as IDLE.
  - On out_ready without in_valid: go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is never high in EXEC.
- Arithmetic: all modulo 2^WIDTH.
- Z = (alu_out==0); N = alu_out[WIDTH-1].
- ADD: C = carry out; V = signed overflow.
- SUB: C = borrow (A<B unsigned); V = signed overflow.
- Shifts: C = last bit shifted out, or 0 if amount is 0; V = 0.
- MUL: alu_out = low WIDTH bits; C = V = (high half ≠ 0).
- Logic and pass ops: C = V = 0.
- a_is_zero is computed from the captured A and updates with alu_out.

## Timing
- Reset (async assert, sync release): state IDLE; alu_out=0, flags=0, a_is_zero=0, op_err=0, out_valid=0, in_ready=1.
- Reset mid-EXEC or mid-DONE aborts the operation. No output is produced for it.
- Latency from accept to out_valid:
  - single-cycle ops: 1
  - shift by k>0: 1+k
  - MUL: WIDTH+1
- Throughput: 1 op/cycle for single-cycle ops when out_ready is held high.
- out_valid and the held data must not change while out_valid && !out_ready.
- in_valid while in_ready=0 is not accepted. The source must hold its request.

## Configuration
- ALU_MUL_EN defined: opcode D is the shift-add multiplier (WIDTH-cycle EXEC).
- ALU_MUL_EN undefined: the product register and MUL path are absent. Opcode D is treated as illegal (pass A, op_err=1, latency 1).

## Structure
- Shared package alu_seq_pkg holds:
  - the opcode constants (OP_HLT…OP_MUL)
  - the state enum {IDLE,EXEC,DONE}
  - the flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0)
- Sub-module alu_seq_comb: the pure combinational single-cycle datapath (ops 0–9, E/F) with flag generation. It is instantiated once.
- The FSM, shifter and multiplier sequencing live in alu_seq.

## Test plan
- Reset, then ADD A=0x7F B=0x01 with out_ready=1 -> one cycle later alu_out=0x80, flags N=1 Z=0 C=0 V=1, out_valid for 1 cycle.
- SUB A=0x00 B=0x01 -> alu_out=0xFF, C=1, N=1, V=0. Then opcode E with A=0x5A -> alu_out=0x5A, op_err=1.
- SHL A=0x81 amount 3 -> in_ready low for 3 cycles, out_valid on cycle 4, alu_out=0x08, C=0. SRA A=0x80 amount 7 -> alu_out=0xFF, C=0.
- MUL A=0x10 B=0x20 with ALU_MUL_EN -> out_valid after 9 cycles, alu_out=0x00, C=V=1, Z=1. Without ALU_MUL_EN -> alu_out=0x10, op_err=1 after 1 cycle.
- Back-pressure: ADD 3+4 with out_ready=0 for 5 cycles -> alu_out=0x07 held, in_ready=0. Release out_ready with in_valid XOR 0xF0^0x0F -> next cycle alu_out=0xFF.
- Assert rst_n low during MUL EXEC cycle 4 -> all outputs 0 immediately, in_ready=1 after release, no stale result emitted.
